// File: rtl/serial_op_seq_v.sv
// serial_op_seq_v: bit-serial operation sequencer. Streams two WIDTH-bit
// operands LSB first to an external combinational bit unit, carries a ripple
// carry between bit steps and assembles the returned bits into a result.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), synchronous active-low reset
//   i_start               begin an operation
//   i_op_a, i_op_b        operands (WIDTH bits)
//   i_code, i_cin         bit-unit function select, initial carry
//   o_a, o_b, o_c         current A bit, B bit and carry to the bit unit
//   o_code                latched function select to the bit unit
//   i_f                   bit-unit result, same cycle
//   o_result, o_cout      assembled result and final carry
//   o_busy, o_done        operation in progress, one-cycle completion pulse
//
// Build option: define SERIAL_OP_SEQ_ABORT_EN to let i_start restart an
// operation that is in RUN or DONE (the aborted one never signals o_done).
// Without it, i_start is only honoured in IDLE.
module serial_op_seq_v #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic [1:0]       i_code,
    input  logic             i_cin,
    output logic             o_a,
    output logic             o_b,
    output logic             o_c,
    output logic [1:0]       o_code,
    input  logic             i_f,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout,
    output logic             o_busy,
    output logic             o_done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [1:0]       r_code;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_load;
    logic             w_last;
    logic             w_run;

    assign w_run  = (r_state == S_RUN);
    assign w_last = w_run && (r_cnt == CW'(WIDTH - 1));

`ifdef SERIAL_OP_SEQ_ABORT_EN
    assign w_load = i_start;
`else
    assign w_load = i_start && (r_state == S_IDLE);
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a load always (re)enters RUN
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (i_start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_load) begin
            w_next = S_RUN;
        end
    end

    // Datapath: operand shifters, carry, step counter, result assembly
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_code  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_a     <= i_op_a;
            r_b     <= i_op_b;
            r_code  <= i_code;
            r_carry <= i_cin;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            // Returned bits enter at the MSB so the first one ends at bit 0
            r_res   <= {i_f, r_res[WIDTH-1:1]};
            // Adder-style carry, independent of the selected function
            r_carry <= (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    // Outputs
    always_comb begin
        o_a      = w_run ? r_a[0] : 1'b0;
        o_b      = w_run ? r_b[0] : 1'b0;
        o_c      = w_run ? r_carry : 1'b0;
        o_code   = r_code;
        o_result = r_res;
        o_cout   = r_carry;
        o_busy   = (r_state != S_IDLE);
`ifdef SERIAL_OP_SEQ_ABORT_EN
        // A restart issued in DONE discards that completion
        o_done   = (r_state == S_DONE) && !i_start;
`else
        o_done   = (r_state == S_DONE);
`endif
    end

endmodule

// File: tb/tb_serial_op_seq_v.sv
// tb_serial_op_seq_v: self-checking bench for serial_op_seq_v with a
// behavioural bit unit and an arithmetic reference model.
module tb_serial_op_seq_v;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [1:0]   code;
    logic         cin;
    logic         o_a;
    logic         o_b;
    logic         o_c;
    logic [1:0]   o_code;
    logic         f;
    logic [W-1:0] result;
    logic         cout;
    logic         busy;
    logic         done;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    serial_op_seq_v #(.WIDTH(W)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_op_a   (op_a),
        .i_op_b   (op_b),
        .i_code   (code),
        .i_cin    (cin),
        .o_a      (o_a),
        .o_b      (o_b),
        .o_c      (o_c),
        .o_code   (o_code),
        .i_f      (f),
        .o_result (result),
        .o_cout   (cout),
        .o_busy   (busy),
        .o_done   (done)
    );

    // Bit unit: 00 XOR3, 01 NAND3, 10 NOR3, 11 majority
    always_comb begin
        f = 1'b0;
        case (o_code)
            2'b00:   f = o_a ^ o_b ^ o_c;
            2'b01:   f = ~(o_a & o_b & o_c);
            2'b10:   f = ~(o_a | o_b | o_c);
            default: f = (o_a & o_b) | (o_c & (o_a ^ o_b));
        endcase
    end

    // Whole-word model: carries come from an ordinary addition,
    // cv[i] is the carry entering bit i.
    function automatic void ref_op(
        input  logic [W-1:0] a,
        input  logic [W-1:0] b,
        input  logic [1:0]   cd,
        input  logic         ci,
        output logic [W-1:0] r,
        output logic         co,
        output logic [W-1:0] cv
    );
        logic [W:0] s;
        s  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        cv = s[W-1:0] ^ a ^ b;
        co = s[W];
        case (cd)
            2'b00:   r = s[W-1:0];
            2'b01:   r = ~(a & b & cv);
            2'b10:   r = ~(a | b | cv);
            default: r = (a & b) | (cv & (a ^ b));
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic scramble;
        op_a = W'($urandom);
        op_b = W'($urandom);
        code = 2'($urandom);
        cin  = 1'($urandom);
    endtask

    // Leaves the bench in RUN cycle 1 (the start cycle is cycle 0)
    task automatic start_op(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [1:0]   cd,
        input logic         ci
    );
        op_a  = a;
        op_b  = b;
        code  = cd;
        cin   = ci;
        start = 1'b1;
        tick();
        start = 1'b0;
        scramble();
    endtask

    // Cycle number at which o_done is seen, 40 if it never comes
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b1;
        op_a  = 8'hFF;
        op_b  = 8'hFF;
        code  = 2'b11;
        cin   = 1'b1;
        tick();
        tick();
        n_total++;
        if ({busy, done} !== 2'b00) begin
            $display("FAIL reset_flags busy/done=%b want 00", {busy, done});
        end else n_pass++;
        n_total++;
        if ({cout, result} !== '0) begin
            $display("FAIL reset_result cout=%b res=%h want 0/00", cout, result);
        end else n_pass++;
        n_total++;
        if ({o_code, o_a, o_b, o_c} !== 5'b0) begin
            $display("FAIL reset_unit code=%b abc=%b%b%b want 0", o_code, o_a, o_b, o_c);
        end else n_pass++;
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        n_total++;
        if (busy !== 1'b0) begin
            $display("FAIL reset_release busy=%b want 0", busy);
        end else n_pass++;
    endtask

    task automatic test_vectors;
        logic [W-1:0] va [4] = '{8'h5A, 8'hFF, 8'hF0, 8'h00};
        logic [W-1:0] vb [4] = '{8'h3C, 8'h01, 8'hCC, 8'h00};
        logic [1:0]   vc [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
        logic [W-1:0] er [4] = '{8'h96, 8'h00, 8'h7F, 8'hFF};
        logic         eo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int cyc;
        for (int i = 0; i < 4; i++) begin
            start_op(va[i], vb[i], vc[i], 1'b0);
            wait_done(cyc);
            n_total++;
            if (cyc !== W + 1) begin
                $display("FAIL vec%0d_latency cycle=%0d want %0d", i, cyc, W + 1);
            end else n_pass++;
            n_total++;
            if (result !== er[i] || cout !== eo[i] || busy !== 1'b1) begin
                $display("FAIL vec%0d_result res=%h cout=%b busy=%b want %h/%b/1",
                         i, result, cout, busy, er[i], eo[i]);
            end else n_pass++;
            tick();
            n_total++;
            if (done !== 1'b0 || busy !== 1'b0 || result !== er[i]) begin
                $display("FAIL vec%0d_after done=%b busy=%b res=%h want 0/0/%h",
                         i, done, busy, result, er[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b, r, cv;
        logic [1:0]   cd;
        logic         ci, co;
        for (int n = 0; n < 24; n++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            cd = 2'($urandom);
            ci = 1'($urandom);
            ref_op(a, b, cd, ci, r, co, cv);
            start_op(a, b, cd, ci);
            for (int k = 0; k < W; k++) begin
                n_total++;
                if ({o_a, o_b, o_c, o_code, busy, done} !== {a[k], b[k], cv[k], cd, 2'b10}) begin
                    $display("FAIL rnd%0d_bit%0d abc=%b%b%b code=%b busy=%b done=%b want %b%b%b/%b/1/0",
                             n, k, o_a, o_b, o_c, o_code, busy, done, a[k], b[k], cv[k], cd);
                end else n_pass++;
                tick();
            end
            n_total++;
            if (done !== 1'b1 || result !== r || cout !== co) begin
                $display("FAIL rnd%0d_result done=%b res=%h cout=%b want 1/%h/%b",
                         n, done, result, cout, r, co);
            end else n_pass++;
            tick();
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic test_hold;
        logic [W-1:0] a, b, r, cv;
        logic [1:0]   cd;
        logic         ci, co;
        int           cyc;
        a  = W'($urandom);
        b  = W'($urandom);
        cd = 2'($urandom);
        ci = 1'($urandom);
        ref_op(a, b, cd, ci, r, co, cv);
        start_op(a, b, cd, ci);
        wait_done(cyc);
        tick();
        for (int i = 0; i < 6; i++) begin
            scramble();
            tick();
            n_total++;
            if (result !== r || cout !== co || o_code !== cd ||
                {o_a, o_b, o_c, busy, done} !== 5'b0) begin
                $display("FAIL hold%0d res=%h cout=%b code=%b abc/busy/done=%b want %h/%b/%b/0",
                         i, result, cout, o_code, {o_a, o_b, o_c, busy, done}, r, co, cd);
            end else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] a1, b1, a2, b2, r1, r2, cv;
        logic         co1, co2;
        int           cyc;
        a1 = W'($urandom);
        b1 = W'($urandom);
        a2 = W'($urandom);
        b2 = W'($urandom);
        ref_op(a1, b1, 2'b00, 1'b1, r1, co1, cv);
        ref_op(a2, b2, 2'b01, 1'b0, r2, co2, cv);
        start_op(a1, b1, 2'b00, 1'b1);
        wait_done(cyc);
        n_total++;
        if (cyc !== W + 1 || result !== r1 || cout !== co1) begin
            $display("FAIL b2b_first cycle=%0d res=%h cout=%b want %0d/%h/%b",
                     cyc, result, cout, W + 1, r1, co1);
        end else n_pass++;
        op_a  = a2;
        op_b  = b2;
        code  = 2'b01;
        cin   = 1'b0;
        start = 1'b1;
        tick();
`ifdef SERIAL_OP_SEQ_ABORT_EN
        n_total++;
        if (busy !== 1'b1) begin
            $display("FAIL b2b_done_start busy=%b want 1", busy);
        end else n_pass++;
`else
        n_total++;
        if (busy !== 1'b0) begin
            $display("FAIL b2b_done_start busy=%b want 0", busy);
        end else n_pass++;
        tick();
`endif
        start = 1'b0;
        scramble();
        wait_done(cyc);
        n_total++;
        if (cyc !== W + 1 || result !== r2 || cout !== co2) begin
            $display("FAIL b2b_second cycle=%0d res=%h cout=%b want %0d/%h/%b",
                     cyc, result, cout, W + 1, r2, co2);
        end else n_pass++;
        tick();
    endtask

    task automatic test_abort_reset;
        int pulses;
        start_op(8'h5A, 8'h3C, 2'b00, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        n_total++;
        if (busy !== 1'b0 || result !== 8'h00 || done !== 1'b0) begin
            $display("FAIL rst_run busy=%b res=%h done=%b want 0/00/0", busy, result, done);
        end else n_pass++;
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        n_total++;
        if (pulses !== 0 || result !== 8'h00) begin
            $display("FAIL rst_run_after done_pulses=%0d res=%h want 0/00", pulses, result);
        end else n_pass++;
    endtask

    task automatic test_restart;
        int           cyc, first, pulses;
        logic [W-1:0] rres;
        int           exp_cyc;
        logic [W-1:0] exp_res;
`ifdef SERIAL_OP_SEQ_ABORT_EN
        exp_cyc = 2 + W + 1;
        exp_res = 8'h02;
`else
        exp_cyc = W + 1;
        exp_res = 8'h96;
`endif
        start_op(8'h5A, 8'h3C, 2'b00, 1'b0);
        tick();
        op_a  = 8'h01;
        op_b  = 8'h01;
        code  = 2'b00;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start  = 1'b0;
        cyc    = 3;
        first  = -1;
        pulses = 0;
        rres   = '0;
        while (cyc < 24) begin
            if (done === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = cyc;
                    rres  = result;
                end
            end
            tick();
            cyc++;
        end
        n_total++;
        if (first !== exp_cyc || pulses !== 1) begin
            $display("FAIL restart_timing done_cycle=%0d pulses=%0d want %0d/1",
                     first, pulses, exp_cyc);
        end else n_pass++;
        n_total++;
        if (rres !== exp_res) begin
            $display("FAIL restart_result res=%h want %h", rres, exp_res);
        end else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        code  = '0;
        cin   = 1'b0;
        test_reset();
        test_vectors();
        test_random();
        test_hold();
        test_back_to_back();
        test_abort_reset();
        test_restart();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
